// File: rtl/bam_prod_accum.sv
// Frame accumulator behind the BAM multiplier: registers P, sums FRAME_LEN products.
// Define BAM_ACC_SAT_EN to saturate the sum instead of wrapping.
module bam_prod_accum #(
    parameter int P_W       = 16,
    parameter int ACC_W     = 24,
    parameter int FRAME_LEN = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [P_W-1:0]   P,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] ACC,
    output logic             OVF
);

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [7:0] LAST = 8'(FRAME_LEN - 1);

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [P_W-1:0]   p_q, p_d;
    logic             pv_q, pv_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W:0]   sum;
    logic             accept;

    assign in_ready = rst_n & ~clr & (state_q == ACCUM);
    assign accept   = in_valid & in_ready;
    assign sum      = {1'b0, acc_q}
                    + {{(ACC_W + 1 - P_W){1'b0}}, p_q};
    assign ACC      = acc_q;
    assign OVF      = ovf_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        p_d       = p_q;
        pv_d      = accept;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        out_valid = (state_q == DONE);

        if (accept) begin
            p_d = P;
        end

        // Stage 2: the carry out of the extended sum is the overflow flag
        if (pv_q) begin
`ifdef BAM_ACC_SAT_EN
            acc_d = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
            acc_d = sum[ACC_W-1:0];
`endif
            ovf_d = ovf_q | sum[ACC_W];
        end

        unique case (state_q)
            ACCUM: begin
                if (accept) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == LAST) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = ACCUM;
                    cnt_d   = '0;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            state_q <= ACCUM;
            cnt_q   <= '0;
            p_q     <= '0;
            pv_q    <= 1'b0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            pv_q    <= pv_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_bam_prod_accum.sv
// Bench for bam_prod_accum: three parameterisations sharing one input stream,
// each checked against a frame-level model, plus directed frames with literal results.
module tb_bam_prod_accum;

    logic        clk = 1'b0;
    logic        rst_n, clr, in_valid, out_ready;
    logic [15:0] P;

    logic        rdy_a, ov_a, ovf_a;
    logic [23:0] acc_a;
    logic        rdy_b, ov_b, ovf_b;
    logic [16:0] acc_b;
    logic        rdy_c, ov_c, ovf_c;
    logic [23:0] acc_c;

    int checks   = 0;
    int failures = 0;
    bit run      = 1'b0;

    always #5 clk = ~clk;

    bam_prod_accum #(.P_W(16), .ACC_W(24), .FRAME_LEN(4)) u_a (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid),
        .in_ready(rdy_a), .P(P), .out_valid(ov_a), .out_ready(out_ready),
        .ACC(acc_a), .OVF(ovf_a));

    bam_prod_accum #(.P_W(16), .ACC_W(17), .FRAME_LEN(4)) u_b (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid),
        .in_ready(rdy_b), .P(P), .out_valid(ov_b), .out_ready(out_ready),
        .ACC(acc_b), .OVF(ovf_b));

    bam_prod_accum #(.P_W(16), .ACC_W(24), .FRAME_LEN(1)) u_c (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid),
        .in_ready(rdy_c), .P(P), .out_valid(ov_c), .out_ready(out_ready),
        .ACC(acc_c), .OVF(ovf_c));

    // Frame-level model: exact running sum, products taken, and the two
    // post-frame phases (last product draining, result waiting)
    typedef struct packed {
        int     n;
        longint sum;
        bit     drain;
        bit     done;
    } model_t;

    model_t ma = '0;
    model_t mb = '0;
    model_t mc = '0;

    function automatic model_t step(model_t m, int fl);
        model_t r = m;
        if (!rst_n || clr) begin
            r = '0;
        end else if (m.done) begin
            if (out_ready) r = '0;
        end else if (m.drain) begin
            r.drain = 1'b0;
            r.done  = 1'b1;
        end else if (in_valid) begin
            r.sum = m.sum + longint'(P);
            r.n   = m.n + 1;
            if (r.n == fl) r.drain = 1'b1;
        end
        return r;
    endfunction

    function automatic bit pred_rdy(model_t m);
        return rst_n && !clr && !m.drain && !m.done;
    endfunction

    function automatic longint exp_acc(longint s, int w);
        longint mx = (longint'(1) << w) - 1;
`ifdef BAM_ACC_SAT_EN
        return (s > mx) ? mx : s;
`else
        return s & mx;
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_dut(input string t, input model_t m, input int w,
                             input logic rdy, input logic ov,
                             input logic [63:0] acc, input logic ovf);
        longint mx = (longint'(1) << w) - 1;
        chk({t, "_in_ready"}, 64'(rdy), 64'(pred_rdy(m)));
        chk({t, "_out_valid"}, 64'(ov), 64'(m.done));
        if (m.done) begin
            chk({t, "_acc"}, acc, 64'(exp_acc(m.sum, w)));
            chk({t, "_ovf"}, 64'(ovf), 64'(m.sum > mx));
        end else if (m.n == 0 && !m.drain) begin
            chk({t, "_acc_idle"}, acc, 64'd0);
            chk({t, "_ovf_idle"}, 64'(ovf), 64'd0);
        end
    endtask

    always @(posedge clk) begin
        ma <= step(ma, 4);
        mb <= step(mb, 4);
        mc <= step(mc, 1);
    end

    always @(negedge clk) begin
        if (run) begin
            check_dut("a", ma, 24, rdy_a, ov_a, 64'(acc_a), ovf_a);
            check_dut("b", mb, 17, rdy_b, ov_b, 64'(acc_b), ovf_b);
            check_dut("c", mc, 24, rdy_c, ov_c, 64'(acc_c), ovf_c);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Offer p after gap idle cycles and hold it until the selected DUT takes it
    task automatic send(input logic [15:0] p, input int sel, input int gap);
        bit took = 1'b0;
        int n    = 0;
        in_valid = 1'b0;
        repeat (gap) tick();
        in_valid = 1'b1;
        P        = p;
        do begin
            #1;
            took = (sel == 2) ? rdy_c : rdy_a;
            tick();
            n++;
        end while (!took && n < 50);
        chk("send_accepted", 64'(took), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input int sel, input int maxc);
        int  n = 0;
        logic v;
        @(negedge clk);
        v = (sel == 2) ? ov_c : ov_a;
        while (!v && n < maxc) begin
            @(negedge clk);
            v = (sel == 2) ? ov_c : ov_a;
            n++;
        end
        chk("result_seen", 64'(v), 64'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] sat_b;
`ifdef BAM_ACC_SAT_EN
        sat_b = 64'h1FFFF;
`else
        sat_b = 64'h1FFFC;
`endif
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0;
        out_ready = 1'b1; P = '0;
        tick();
        run = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", 64'(rdy_a), 64'd0);
        chk("reset_out_valid", 64'(ov_a), 64'd0);
        chk("reset_acc", 64'(acc_a), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Back-to-back frame; result appears two cycles after the last accept
        send(16'd100, 0, 0); send(16'd200, 0, 0);
        send(16'd300, 0, 0); send(16'd400, 0, 0);
        @(negedge clk);
        chk("t1_valid_drain", 64'(ov_a), 64'd0);
        chk("t1_ready_drain", 64'(rdy_a), 64'd0);
        @(negedge clk);
        chk("t1_valid", 64'(ov_a), 64'd1);
        chk("t1_acc", 64'(acc_a), 64'd1000);
        chk("t1_ovf", 64'(ovf_a), 64'd0);
        @(negedge clk);
        chk("t1_valid_drop", 64'(ov_a), 64'd0);
        tick();

        // Backpressure with a held input that must not be consumed
        out_ready = 1'b0;
        send(16'd100, 0, 0); send(16'd200, 0, 0);
        send(16'd300, 0, 0); send(16'd400, 0, 0);
        in_valid = 1'b1;
        P        = 16'd7;
        @(negedge clk);
        repeat (5) begin
            @(negedge clk);
            chk("t2_valid_hold", 64'(ov_a), 64'd1);
            chk("t2_acc_hold", 64'(acc_a), 64'd1000);
            chk("t2_ready_hold", 64'(rdy_a), 64'd0);
        end
        tick();
        out_ready = 1'b1;
        send(16'd7, 0, 0);
        send(16'd1, 0, 0); send(16'd2, 0, 0); send(16'd3, 0, 0);
        wait_valid(0, 10);
        chk("t2_next_acc", 64'(acc_a), 64'd13);
        tick();

        // Gapped max products: fits in 24 bits, overflows 17 bits
        for (int i = 0; i < 4; i++) begin
            send(16'hFFFF, 0, (i == 0) ? 0 : int'($urandom_range(1, 3)));
        end
        wait_valid(0, 10);
        chk("t3_acc", 64'(acc_a), 64'h3FFFC);
        chk("t3_ovf", 64'(ovf_a), 64'd0);
        chk("t4_acc", 64'(acc_b), sat_b);
        chk("t4_ovf", 64'(ovf_b), 64'd1);
        tick();
        for (int i = 0; i < 4; i++) send(16'd1, 0, 0);
        wait_valid(0, 10);
        chk("t4_next_acc", 64'(acc_b), 64'd4);
        chk("t4_next_ovf", 64'(ovf_b), 64'd0);
        tick();

        // Abort a partial frame, first by reset then by clr
        for (int k = 0; k < 2; k++) begin
            send(16'd50, 0, 0); send(16'd60, 0, 0);
            if (k == 0) rst_n = 1'b0;
            else        clr   = 1'b1;
            @(negedge clk);
            chk("t5_ready_abort", 64'(rdy_a), 64'd0);
            tick();
            rst_n = 1'b1;
            clr   = 1'b0;
            @(negedge clk);
            chk("t5_acc_cleared", 64'(acc_a), 64'd0);
            chk("t5_valid_cleared", 64'(ov_a), 64'd0);
            chk("t5_ovf_cleared", 64'(ovf_a), 64'd0);
            tick();
            send(16'd1, 0, 0); send(16'd2, 0, 0);
            send(16'd3, 0, 0); send(16'd4, 0, 0);
            wait_valid(0, 10);
            chk("t5_acc", 64'(acc_a), 64'd10);
            tick();
        end

        // Single-product frames, then clr while the result waits
        out_ready = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        send(16'hABCD, 2, 0);
        @(negedge clk);
        chk("t6_valid_drain", 64'(ov_c), 64'd0);
        @(negedge clk);
        chk("t6_valid", 64'(ov_c), 64'd1);
        chk("t6_acc", 64'(acc_c), 64'hABCD);
        tick();
        clr = 1'b1;
        in_valid = 1'b1;
        P = 16'd5;
        @(negedge clk);
        chk("t6_clr_no_accept", 64'(rdy_a), 64'd0);
        tick();
        clr = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("t6_valid_cleared", 64'(ov_c), 64'd0);
        chk("t6_acc_cleared", 64'(acc_c), 64'd0);
        tick();

        // Random traffic, compared every cycle against the model
        out_ready = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            clr       = ($urandom_range(0, 59) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            P         = ($urandom_range(0, 3) == 0) ? 16'hFFFF
                                                    : 16'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        rst_n = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) tick();
        run = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
